// File: rtl/bulk_endp_pkg.sv
// Shared definitions for the bulk endpoint pair: FSM encoding, pointer
// width helper and PID toggle values.
package bulk_endp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_NAK      = 2'd1,
      ST_SEND     = 2'd2,
      ST_WAIT_ACK = 2'd3
   } endp_state_t;

   localparam logic PID_DATA0 = 1'b0;
   localparam logic PID_DATA1 = 1'b1;

   // One extra bit so full and empty are distinguishable.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/bulk_in_ram.sv
// Byte buffer for the bulk IN endpoint: one synchronous write port and one
// asynchronous read port.
module bulk_in_ram #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/bulk_in_endp_pkt.sv
// Full-speed bulk IN endpoint with packet-aware buffering, retransmission of
// unacked packets, DATA0/DATA1 tracking and a short-packet hold-off timer.
// Optional ZLP termination after a full-size packet: define BULK_IN_ZLP_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no transaction; waits for an IN token (in_req_i rise)
// NAK      | nothing sendable; in_nak_o held until in_req_i falls
// SEND     | streaming pkt_len bytes from base_ptr to the SIE
// WAIT_ACK | packet out; ACK commits it, in_req_i fall rewinds for resend
module bulk_in_endp_pkt
   import bulk_endp_pkg::*;
#(
   parameter int MAXPACKETSIZE = 64,
   parameter int DEPTH         = 256,
   parameter int SHORT_TIMEOUT = 0
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [7:0]                   app_in_data_i,
   input  logic                         app_in_valid_i,
   output logic                         app_in_ready_o,
   input  logic                         in_req_i,
   output logic                         in_valid_o,
   output logic [7:0]                   in_data_o,
   input  logic                         in_ready_i,
   input  logic                         in_data_ack_i,
   output logic                         in_nak_o,
   output logic                         in_toggle_o,
   input  logic                         toggle_clr_i,
   output logic [ptr_width(DEPTH)-1:0]  level_o
);

   localparam int PW = ptr_width(DEPTH);
   localparam int AW = PW - 1;
   localparam int TW = $clog2(SHORT_TIMEOUT + 2);

   localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
   localparam logic [PW-1:0] MPS_P   = PW'(MAXPACKETSIZE);
   localparam logic [TW-1:0] TMO_P   = TW'(SHORT_TIMEOUT);

   endp_state_t   state, state_nxt;

   logic [PW-1:0] wr_ptr, base_ptr, rd_ptr;
   logic [PW-1:0] pkt_len;
   logic [PW-1:0] level, sent, len_now;
   logic [TW-1:0] idle_cnt;
   logic          toggle;
   logic          zlp_pending;
   logic          in_req_q;

   logic          full, wr_en, req_rise, eligible;
   logic          byte_take, ack_take, abort;

   assign level    = wr_ptr - base_ptr;
   assign sent     = rd_ptr - base_ptr;
   assign full     = (level == DEPTH_P);
   assign wr_en    = app_in_valid_i & ~full;
   assign req_rise = in_req_i & ~in_req_q;
   assign len_now  = (level >= MPS_P) ? MPS_P : level;

   assign eligible = (level >= MPS_P)
                   | ((level != '0) & (idle_cnt == TMO_P))
                   | zlp_pending;

   assign byte_take = (state == ST_SEND) & in_req_i & in_ready_i & (sent != pkt_len);
   assign ack_take  = (state == ST_WAIT_ACK) & in_data_ack_i;
   // ACK beats a same-cycle in_req_i fall, so abort excludes it.
   assign abort     = ~in_req_i & ((state == ST_SEND) |
                                   ((state == ST_WAIT_ACK) & ~in_data_ack_i));

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            if (req_rise) begin
               if (!eligible)         state_nxt = ST_NAK;
               else if (len_now == '0) state_nxt = ST_WAIT_ACK;
               else                   state_nxt = ST_SEND;
            end
         end
         ST_NAK: begin
            if (!in_req_i) state_nxt = ST_IDLE;
         end
         ST_SEND: begin
            if (!in_req_i)                                    state_nxt = ST_IDLE;
            else if (byte_take && (sent + PW'(1) == pkt_len)) state_nxt = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (in_data_ack_i || !in_req_i) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= ST_IDLE;
         in_req_q <= 1'b0;
         wr_ptr   <= '0;
         base_ptr <= '0;
         rd_ptr   <= '0;
         pkt_len  <= '0;
         idle_cnt <= '0;
         toggle   <= PID_DATA0;
      end else begin
         state    <= state_nxt;
         in_req_q <= in_req_i;

         if (wr_en) wr_ptr <= wr_ptr + PW'(1);

         if ((state == ST_IDLE) && req_rise) pkt_len <= len_now;

         if (ack_take) base_ptr <= rd_ptr;

         if (abort)          rd_ptr <= base_ptr;
         else if (byte_take) rd_ptr <= rd_ptr + PW'(1);

         if (toggle_clr_i)  toggle <= PID_DATA0;
         else if (ack_take) toggle <= ~toggle;

         if (wr_en)                                   idle_cnt <= '0;
         else if ((level != '0) && (idle_cnt != TMO_P)) idle_cnt <= idle_cnt + TW'(1);
      end
   end

`ifdef BULK_IN_ZLP_EN
   // A full packet that drains the buffer is followed by a ZLP unless new
   // data arrives first; the ZLP's own ACK (pkt_len 0) clears the flag.
   always_ff @(posedge clk_i) begin
      if (rst_i)         zlp_pending <= 1'b0;
      else if (wr_en)    zlp_pending <= 1'b0;
      else if (ack_take) zlp_pending <= (pkt_len == MPS_P) && (wr_ptr == rd_ptr);
   end
`else
   assign zlp_pending = 1'b0;
`endif

   bulk_in_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk_i (clk_i),
      .we    (wr_en),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (app_in_data_i),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (in_data_o)
   );

   assign app_in_ready_o = ~full;
   assign in_valid_o     = (state == ST_SEND) && (sent != pkt_len);
   assign in_nak_o       = (state == ST_NAK);
   assign in_toggle_o    = toggle;
   assign level_o        = level;

endmodule

// File: tb/tb_bulk_in_endp_pkt.sv
// Bench for bulk_in_endp_pkt: queue-based reference model checked every cycle
// on instance A, plus directed literal checks on both instances.
module tb_bulk_in_endp_pkt;

   localparam int MPS     = 8;
   localparam int DEPTH_A = 16;
   localparam int ST_A    = 0;
   localparam int DEPTH_B = 64;
   localparam int ST_B    = 100;

`ifdef BULK_IN_ZLP_EN
   localparam bit ZLP_EN = 1'b1;
`else
   localparam bit ZLP_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic [7:0] a_wdata, a_data;
   logic       a_wvalid, a_wready, a_req, a_valid, a_rdy, a_ack, a_nak, a_tog, a_clr;
   logic [4:0] a_level;

   logic [7:0] b_wdata, b_data;
   logic       b_wvalid, b_wready, b_req, b_valid, b_rdy, b_ack, b_nak, b_tog, b_clr;
   logic [6:0] b_level;

   bulk_in_endp_pkt #(.MAXPACKETSIZE(MPS), .DEPTH(DEPTH_A), .SHORT_TIMEOUT(ST_A)) dut_a (
      .clk_i(clk), .rst_i(rst),
      .app_in_data_i(a_wdata), .app_in_valid_i(a_wvalid), .app_in_ready_o(a_wready),
      .in_req_i(a_req), .in_valid_o(a_valid), .in_data_o(a_data), .in_ready_i(a_rdy),
      .in_data_ack_i(a_ack), .in_nak_o(a_nak), .in_toggle_o(a_tog),
      .toggle_clr_i(a_clr), .level_o(a_level));

   bulk_in_endp_pkt #(.MAXPACKETSIZE(MPS), .DEPTH(DEPTH_B), .SHORT_TIMEOUT(ST_B)) dut_b (
      .clk_i(clk), .rst_i(rst),
      .app_in_data_i(b_wdata), .app_in_valid_i(b_wvalid), .app_in_ready_o(b_wready),
      .in_req_i(b_req), .in_valid_o(b_valid), .in_data_o(b_data), .in_ready_i(b_rdy),
      .in_data_ack_i(b_ack), .in_nak_o(b_nak), .in_toggle_o(b_tog),
      .toggle_clr_i(b_clr), .level_o(b_level));

   int n_vec  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model for instance A: buffer is a byte queue whose head is
   // the oldest unacked byte; mode 0 idle, 1 nak, 2 sending, 3 awaiting ACK.
   logic [7:0] mq[$];
   int  m_mode, m_sent, m_plen, m_idle, m_lvl;
   bit  m_tog, m_zlp, m_reqq, m_wr, m_live = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         m_mode = 0; m_sent = 0; m_plen = 0; m_idle = 0;
         m_tog = 1'b0; m_zlp = 1'b0; m_reqq = 1'b0; m_live = 1'b1;
      end else if (m_live) begin
         m_lvl = mq.size();
         m_wr  = a_wvalid && (m_lvl < DEPTH_A);
         case (m_mode)
            0: if (a_req && !m_reqq) begin
                  if (m_lvl >= MPS || (m_lvl > 0 && m_idle == ST_A) || m_zlp) begin
                     m_plen = (m_lvl < MPS) ? m_lvl : MPS;
                     m_sent = 0;
                     m_mode = (m_plen == 0) ? 3 : 2;
                  end else begin
                     m_mode = 1;
                  end
               end
            1: if (!a_req) m_mode = 0;
            2: if (!a_req) begin
                  m_mode = 0; m_sent = 0;
               end else if (a_rdy && m_sent < m_plen) begin
                  m_sent++;
                  if (m_sent == m_plen) m_mode = 3;
               end
            default: if (a_ack) begin
                  for (int i = 0; i < m_plen; i++) void'(mq.pop_front());
                  m_zlp  = ZLP_EN && (m_plen == MPS) && (m_lvl == m_plen);
                  m_tog  = !m_tog;
                  m_mode = 0; m_sent = 0;
               end else if (!a_req) begin
                  m_mode = 0; m_sent = 0;
               end
         endcase
         if (a_clr) m_tog = 1'b0;
         if (m_wr) begin
            mq.push_back(a_wdata);
            m_zlp  = 1'b0;
            m_idle = 0;
         end else if (m_lvl > 0 && m_idle < ST_A) begin
            m_idle++;
         end
         m_reqq = a_req;
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         chk("a_valid", a_valid, (m_mode == 2 && m_sent < m_plen));
         chk("a_nak", a_nak, (m_mode == 1));
         chk("a_toggle", a_tog, m_tog);
         chk("a_level", a_level, mq.size());
         chk("a_ready", a_wready, (mq.size() < DEPTH_A));
         if (m_mode == 2 && m_sent < m_plen) chk("a_data", a_data, mq[m_sent]);
      end
   end

   // Receive capture from the last transaction.
   logic [7:0] rx[16];
   int  rx_n;
   bit  rx_nak, rx_tog;

   task automatic wr_bytes(input bit sel, input int first, input int n);
      for (int i = 0; i < n; i++) begin
         chk(sel ? "b_wr_ready" : "a_wr_ready", sel ? b_wready : a_wready, 1);
         if (sel) begin b_wvalid = 1'b1; b_wdata = 8'(first + i); end
         else     begin a_wvalid = 1'b1; a_wdata = 8'(first + i); end
         @(negedge clk);
      end
      a_wvalid = 1'b0;
      b_wvalid = 1'b0;
   endtask

   task automatic txn(input bit sel, input bit ack, input bit clr_on_ack,
                      input bit wr_on_ack, input int wr_byte);
      bit v;
      rx_n = 0; rx_nak = 1'b0; rx_tog = 1'b0;
      if (sel) b_req = 1'b1; else a_req = 1'b1;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         v = sel ? b_valid : a_valid;
         if (c == 0) rx_tog = sel ? b_tog : a_tog;
         if (sel ? b_nak : a_nak) rx_nak = 1'b1;
         if (v && rx_n < 16) begin
            rx[rx_n] = sel ? b_data : a_data;
            rx_n++;
         end
         if (sel) b_rdy = v; else a_rdy = v;
      end
      a_rdy = 1'b0; b_rdy = 1'b0;
      if (ack) begin
         if (sel) b_ack = 1'b1; else a_ack = 1'b1;
         if (clr_on_ack) begin if (sel) b_clr = 1'b1; else a_clr = 1'b1; end
         if (wr_on_ack) begin
            if (sel) begin b_wvalid = 1'b1; b_wdata = 8'(wr_byte); end
            else     begin a_wvalid = 1'b1; a_wdata = 8'(wr_byte); end
         end
         @(negedge clk);
         a_ack = 1'b0; b_ack = 1'b0; a_clr = 1'b0; b_clr = 1'b0;
         a_wvalid = 1'b0; b_wvalid = 1'b0;
      end
      a_req = 1'b0; b_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic expect_pkt(input string nm, input int first, input int n, input int tog);
      chk({nm, "_len"}, rx_n, n);
      chk({nm, "_nak"}, rx_nak, 0);
      chk({nm, "_tog"}, rx_tog, tog);
      for (int i = 0; i < n && i < rx_n; i++) chk({nm, "_byte"}, rx[i], (first + i) & 255);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      a_wdata = '0; a_wvalid = 0; a_req = 0; a_rdy = 0; a_ack = 0; a_clr = 0;
      b_wdata = '0; b_wvalid = 0; b_req = 0; b_rdy = 0; b_ack = 0; b_clr = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      chk("rst_valid", a_valid, 0);
      chk("rst_nak", a_nak, 0);
      chk("rst_toggle", a_tog, 0);
      chk("rst_level", a_level, 0);
      chk("rst_ready", a_wready, 1);
      chk("rst_b_level", b_level, 0);

      // Fill to capacity: back-pressure asserts
      wr_bytes(0, 0, 16);
      chk("full_ready", a_wready, 0);
      chk("full_level", a_level, 16);

      // Full packet, no ACK: still full, then identical resend
      txn(0, 0, 0, 0, 0);
      expect_pkt("noack_pkt", 0, 8, 0);
      chk("noack_level", a_level, 16);
      chk("noack_ready", a_wready, 0);
      txn(0, 1, 0, 0, 0);
      expect_pkt("resend_pkt", 0, 8, 0);
      chk("ack_level", a_level, 8);
      chk("ack_ready", a_wready, 1);

      // 20 bytes total: 8 DATA0, 8 DATA1, 4 DATA0
      wr_bytes(0, 16, 4);
      txn(0, 1, 0, 0, 0);
      expect_pkt("pkt2", 8, 8, 1);
      txn(0, 1, 0, 0, 0);
      expect_pkt("pkt3", 16, 4, 0);
      chk("drain_level", a_level, 0);

      // Empty buffer: NAK, and an ACK during NAK is ignored
      txn(0, 1, 0, 0, 0);
      chk("empty_nak", rx_nak, 1);
      chk("empty_nak_tog", a_tog, 1);

      // Exactly one full packet, then ZLP or NAK depending on build
      wr_bytes(0, 20, 8);
      txn(0, 1, 0, 0, 0);
      expect_pkt("full_pkt", 20, 8, 1);
      txn(0, 1, 0, 0, 0);
      chk("zlp_len", rx_n, 0);
      chk("zlp_nak", rx_nak, !ZLP_EN);
      chk("zlp_tog", rx_tog, 0);
      chk("tog_after_zlp", a_tog, ZLP_EN ? 1 : 0);

      // toggle_clr alone, then coinciding with an ACK
      a_clr = 1'b1;
      @(negedge clk);
      a_clr = 1'b0;
      chk("clr_tog", a_tog, 0);
      wr_bytes(0, 28, 3);
      txn(0, 1, 1, 0, 0);
      expect_pkt("clr_pkt", 28, 3, 0);
      chk("clr_on_ack_tog", a_tog, 0);

      // Write in the ACK cycle: level = 9 + 1 - 8
      wr_bytes(0, 31, 9);
      txn(0, 1, 0, 1, 40);
      expect_pkt("wrack_pkt", 31, 8, 0);
      chk("wrack_level", a_level, 2);
      chk("wrack_tog", a_tog, 1);

      // Hold-off timer on instance B
      wr_bytes(1, 'hA0, 3);
      repeat (48) @(negedge clk);
      txn(1, 0, 0, 0, 0);
      chk("tmo_early_nak", rx_nak, 1);
      chk("tmo_early_len", rx_n, 0);
      repeat (70) @(negedge clk);
      txn(1, 1, 0, 0, 0);
      expect_pkt("tmo_pkt", 'hA0, 3, 0);
      chk("tmo_level", b_level, 0);
      chk("tmo_tog", b_tog, 1);

      // Reset in the middle of SEND after 3 bytes
      wr_bytes(0, 41, 6);
      chk("pre_rst_level", a_level, 8);
      a_req = 1'b1;
      @(negedge clk);
      a_rdy = 1'b1;
      repeat (3) @(negedge clk);
      a_rdy = 1'b0;
      chk("mid_send_valid", a_valid, 1);
      chk("mid_send_data", a_data, 42);
      rst = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      a_req = 1'b0;
      chk("midrst_valid", a_valid, 0);
      chk("midrst_level", a_level, 0);
      chk("midrst_tog", a_tog, 0);
      chk("midrst_nak", a_nak, 0);
      chk("midrst_ready", a_wready, 1);
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
